// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding and default
// geometry, also used by the PC unit and the hazard unit.
package fetch_ctrl_pkg;

    localparam int          FC_XLEN      = 32;
    localparam logic [31:0] FC_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FC_PC_STEP   = 32'h0000_0001;
    localparam int          FC_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DROP  = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: synchronous FIFO of {pc, instr} pairs with flush. The head is
// held in registers so decode sees stable values, including while empty.
module fetch_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_pc,
    input  logic [XLEN-1:0]        push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [XLEN-1:0]        head_pc,
    output logic [XLEN-1:0]        head_instr
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [XLEN-1:0]  pc_mem_r    [DEPTH];
    logic [XLEN-1:0]  instr_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic [XLEN-1:0]  head_pc_r;
    logic [XLEN-1:0]  head_instr_r;
    logic [XLEN-1:0]  nxt_pc_s;
    logic [XLEN-1:0]  nxt_instr_s;

    // Qualified push/pop, next occupancy and next head entry.
    always_comb begin
        do_push_s    = push && !flush && (count_r != FULL_C);
        do_pop_s     = pop && !flush && (count_r != {CNT_W{1'b0}});
        count_next_s = count_r;
        rd_next_s    = rd_ptr_r;
        if (flush) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_next_s = count_r + CNT_W'(1);
                2'b01:   count_next_s = count_r - CNT_W'(1);
                default: count_next_s = count_r;
            endcase
        end
        if (do_pop_s) begin
            rd_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        // A slot being written this cycle is not in the array yet: bypass it.
        if (do_push_s && (rd_next_s == wr_ptr_r)) begin
            nxt_pc_s    = push_pc;
            nxt_instr_s = push_instr;
        end else begin
            nxt_pc_s    = pc_mem_r[rd_next_s];
            nxt_instr_s = instr_mem_r[rd_next_s];
        end
    end

    // Entry storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            pc_mem_r[wr_ptr_r]    <= push_pc;
            instr_mem_r[wr_ptr_r] <= push_instr;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_pc_r    <= {XLEN{1'b0}};
            head_instr_r <= {XLEN{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            if (count_next_s != {CNT_W{1'b0}}) begin
                head_pc_r    <= nxt_pc_s;
                head_instr_r <= nxt_instr_s;
            end
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign head_pc    = head_pc_r;
    assign head_instr = head_instr_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the IF stage: owns the fetch PC, keeps at most one imem
// request in flight and feeds decode through fetch_buf; redirects flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN      = FC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FC_RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP   = XLEN'(FC_PC_STEP),
    parameter int              BUF_DEPTH = FC_BUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            pc_sel,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_r;
    fetch_state_e     state_next_s;
    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  req_pc_r;
    logic [CNT_W-1:0] buf_count_s;
    logic             redirect_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    // Redirect qualification, request credit and handshake decode.
    always_comb begin
        if (!rst && redirect_valid && (state_r != ST_IDLE)) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
        // Only responses push, so a free slot at issue time is a guaranteed slot.
        if (!rst && (state_r == ST_ISSUE) && (buf_count_s < DEPTH_C)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s = req_valid_s && imem_req_ready;
        push_s   = (state_r == ST_WAIT) && imem_rsp_valid && !redirect_s;
        pop_s    = if_valid && if_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; redirect takes priority over normal sequencing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (redirect_s) begin
                    state_next_s = accept_s ? ST_DROP : ST_ISSUE;
                end else begin
                    state_next_s = accept_s ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (redirect_s) begin
                    state_next_s = imem_rsp_valid ? ST_ISSUE : ST_DROP;
                end else begin
                    state_next_s = imem_rsp_valid ? ST_ISSUE : ST_WAIT;
                end
            end
            ST_DROP: begin
                state_next_s = imem_rsp_valid ? ST_ISSUE : ST_DROP;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs toward the PC unit and instruction memory.
    always_comb begin
        pc_sel         = redirect_s;
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
    end

    // Fetch PC only moves on accept or redirect, keeping the address stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
        end else if (redirect_s) begin
            fetch_pc_r <= redirect_pc;
        end else if (accept_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
    end

    fetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_pc    (req_pc_r),
        .push_instr (imem_rsp_data),
        .pop        (pop_s),
        .flush      (redirect_s),
        .count      (buf_count_s),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

endmodule
